// File: rtl/lc3_pkg.sv
// Shared definitions for the LC-3 control FSM: state encoding, opcodes and
// datapath select encodings.
package lc3_pkg;

    typedef enum logic [4:0] {
        StHalted,
        StFetch1,
        StFetch2,
        StFetch3,
        StDecode,
        StAdd,
        StAnd,
        StNot,
        StBr,
        StBrTaken,
        StJmp,
        StJsr1,
        StJsr2,
        StLdr1,
        StLdr2,
        StLdr3,
        StStr1,
        StStr2,
        StStr3,
        StPause1,
        StPause2
    } state_e;

    localparam logic [3:0] OpBr    = 4'b0000;
    localparam logic [3:0] OpAdd   = 4'b0001;
    localparam logic [3:0] OpJsr   = 4'b0100;
    localparam logic [3:0] OpAnd   = 4'b0101;
    localparam logic [3:0] OpLdr   = 4'b0110;
    localparam logic [3:0] OpStr   = 4'b0111;
    localparam logic [3:0] OpNot   = 4'b1001;
    localparam logic [3:0] OpJmp   = 4'b1100;
    localparam logic [3:0] OpPause = 4'b1101;

    localparam logic [1:0] PcmuxInc   = 2'b00;
    localparam logic [1:0] PcmuxAdder = 2'b01;
    localparam logic [1:0] PcmuxBus   = 2'b10;

    localparam logic [1:0] Addr2Zero   = 2'b00;
    localparam logic [1:0] Addr2Sext6  = 2'b01;
    localparam logic [1:0] Addr2Sext9  = 2'b10;
    localparam logic [1:0] Addr2Sext11 = 2'b11;

    localparam logic [1:0] AlukAdd  = 2'b00;
    localparam logic [1:0] AlukAnd  = 2'b01;
    localparam logic [1:0] AlukNot  = 2'b10;
    localparam logic [1:0] AlukPass = 2'b11;

    // States that hold an SRAM access open for MEM_WAIT+1 cycles.
    function automatic logic is_mem_state(input state_e s);
        return (s == StFetch2) || (s == StLdr2) || (s == StStr3);
    endfunction

endpackage

// File: rtl/lc3_control_fsm_mem_wait_counter.sv
// Memory wait counter: loads the wait count on entry to an access state and
// counts down to zero, where it holds.
module mem_wait_counter (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic [2:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != 3'd0)) begin
            cnt_d = cnt_q - 3'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= 3'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == 3'd0);

endmodule

// File: rtl/lc3_control_fsm.sv
// Moore control FSM for the LC-3 datapath (fetch/decode/execute).
// Define LC3_PAUSE_EN to enable the PAUSE instruction (opcode 1101).
module lc3_control_fsm
    import lc3_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Run,
    input  logic       Continue,
    input  logic [3:0] Opcode,
    input  logic       IR_5,
    input  logic       IR_11,
    input  logic       BEN,
    output logic       LD_PC,
    output logic       LD_MAR,
    output logic       LD_MDR,
    output logic       LD_IR,
    output logic       LD_REG,
    output logic       LD_CC,
    output logic       LD_BEN,
    output logic       GatePC,
    output logic       GateMARMUX,
    output logic       GateALU,
    output logic       GateMDR,
    output logic       DRMUX,
    output logic       SR1MUX,
    output logic       SR2MUX,
    output logic       ADDR1MUX,
    output logic       MIO_EN,
    output logic [1:0] PCMUX,
    output logic [1:0] ADDR2MUX,
    output logic [1:0] ALUK,
    output logic       Mem_CE,
    output logic       Mem_OE,
    output logic       Mem_WE,
    output logic       Paused
);

    state_e state_q, state_d;
    logic   cnt_done;
    logic   cnt_load;
    logic   cnt_dec;

    assign cnt_load = is_mem_state(state_d) && (state_d != state_q);
    assign cnt_dec  = is_mem_state(state_q);

    mem_wait_counter u_mem_wait_counter (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .load_i     (cnt_load),
        .load_val_i (3'(MEM_WAIT)),
        .dec_i      (cnt_dec),
        .done_o     (cnt_done)
    );

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= StHalted;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHalted:  if (Run) state_d = StFetch1;
            StFetch1:  state_d = StFetch2;
            StFetch2:  if (cnt_done) state_d = StFetch3;
            StFetch3:  state_d = StDecode;
            StDecode: begin
                case (Opcode)
                    OpAdd:   state_d = StAdd;
                    OpAnd:   state_d = StAnd;
                    OpNot:   state_d = StNot;
                    OpBr:    state_d = StBr;
                    OpJmp:   state_d = StJmp;
                    OpJsr:   state_d = StJsr1;
                    OpLdr:   state_d = StLdr1;
                    OpStr:   state_d = StStr1;
`ifdef LC3_PAUSE_EN
                    OpPause: state_d = StPause1;
`endif
                    default: state_d = StFetch1;
                endcase
            end
            StAdd, StAnd, StNot, StJmp, StBrTaken, StJsr2, StLdr3: state_d = StFetch1;
            StBr:      state_d = BEN ? StBrTaken : StFetch1;
            StJsr1:    state_d = StJsr2;
            StLdr1:    state_d = StLdr2;
            StLdr2:    if (cnt_done) state_d = StLdr3;
            StStr1:    state_d = StStr2;
            StStr2:    state_d = StStr3;
            StStr3:    if (cnt_done) state_d = StFetch1;
            // Two-phase handshake: one instruction per Continue press.
            StPause1:  if (Continue) state_d = StPause2;
            StPause2:  if (!Continue) state_d = StFetch1;
            default:   state_d = StHalted;
        endcase
    end

    always_comb begin
        LD_PC      = 1'b0;
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_REG     = 1'b0;
        LD_CC      = 1'b0;
        LD_BEN     = 1'b0;
        GatePC     = 1'b0;
        GateMARMUX = 1'b0;
        GateALU    = 1'b0;
        GateMDR    = 1'b0;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        MIO_EN     = 1'b0;
        PCMUX      = PcmuxInc;
        ADDR2MUX   = Addr2Zero;
        ALUK       = AlukAdd;
        Mem_CE     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        Paused     = 1'b0;
        unique case (state_q)
            StFetch1: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                PCMUX  = PcmuxInc;
                LD_PC  = 1'b1;
            end
            StFetch2, StLdr2: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = 1'b1;
            end
            StFetch3: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            StDecode: LD_BEN = 1'b1;
            StAdd, StAnd: begin
                SR2MUX  = IR_5;
                ALUK    = (state_q == StAnd) ? AlukAnd : AlukAdd;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StNot: begin
                ALUK    = AlukNot;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StBrTaken: begin
                ADDR2MUX = Addr2Sext9;
                PCMUX    = PcmuxAdder;
                LD_PC    = 1'b1;
            end
            StJmp: begin
                ALUK    = AlukPass;
                GateALU = 1'b1;
                PCMUX   = PcmuxBus;
                LD_PC   = 1'b1;
            end
            StJsr1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            StJsr2: begin
                if (IR_11) begin
                    ADDR2MUX = Addr2Sext11;
                end else begin
                    ADDR1MUX = 1'b1;
                end
                PCMUX = PcmuxAdder;
                LD_PC = 1'b1;
            end
            StLdr1, StStr1: begin
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = Addr2Sext6;
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
            end
            StLdr3: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            StStr2: begin
                SR1MUX  = 1'b1;
                ALUK    = AlukPass;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            StStr3: begin
                Mem_CE = 1'b0;
                Mem_WE = 1'b0;
            end
`ifdef LC3_PAUSE_EN
            StPause1, StPause2: Paused = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
